// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: FSM state encoding and frame constants.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; a write in the same cycle as a read
// is accepted even when full, since the read frees the slot.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       wr_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       rd_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             wr_ok_s;
  logic             rd_ok_s;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign wr_ok_s = wr_i && (!full_o || rd_ok_s);
  assign rd_ok_s = rd_i && !empty_o;

  // Pointer and occupancy next-state; pointers wrap on the power-of-2 depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_ok_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_ok_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_ok_s, rd_ok_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Control registers; contents are discarded on reset by clearing the pointers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array.
  always_ff @(posedge clk_i) begin
    if (wr_ok_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a write FIFO; bit period is prescale+1 clocks,
// latched per frame. All serial outputs are registered.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int PRESC_W    = 16
) (
  input  logic                          HCLK,
  input  logic                          HRESETn,
  input  logic                          en,
  input  logic [PRESC_W-1:0]            prescale,
  input  logic [7:0]                    wdata,
  input  logic                          wr,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  input  logic                          ovf_clr,
  output logic                          busy,
  output logic                          done,
  output logic                          tx
);

  localparam int                BIT_W    = $clog2(UART_DATA_BITS);
  localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(UART_DATA_BITS - 1);

  uart_state_e               state_q, state_d;
  logic [PRESC_W-1:0]        cnt_q, cnt_d;
  logic [PRESC_W-1:0]        presc_q, presc_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]          bit_q, bit_d;
  logic                      tx_q, tx_d;
  logic                      done_q, done_d;
  logic                      ovf_q, ovf_d;
  logic [UART_DATA_BITS-1:0] fifo_rdata_s;
  logic                      pop_s;
  logic                      drop_s;
  logic                      bit_end_s;

  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (HCLK),
    .rst_ni  (HRESETn),
    .wr_i    (wr),
    .wdata_i (wdata),
    .rd_i    (pop_s),
    .rdata_o (fifo_rdata_s),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  assign bit_end_s = (cnt_q == '0);
  // A new frame may start from IDLE or straight out of the last stop-bit cycle.
  assign pop_s  = en && !empty &&
                  ((state_q == IDLE) || ((state_q == STOP) && bit_end_s));
  assign drop_s = wr && full && !pop_s;

  // Frame sequencer; tx_d is the line level for the cycle after this edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    presc_d = presc_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    if (pop_s) begin
      state_d = START;
      cnt_d   = prescale;
      presc_d = prescale;
      shift_d = fifo_rdata_s;
      bit_d   = '0;
      tx_d    = ~UART_IDLE_LEVEL;
    end else begin
      case (state_q)
        IDLE: begin
          tx_d = UART_IDLE_LEVEL;
        end
        START: begin
          if (bit_end_s) begin
            state_d = DATA;
            cnt_d   = presc_q;
            tx_d    = shift_q[0];
          end else begin
            cnt_d = cnt_q - PRESC_W'(1);
            tx_d  = ~UART_IDLE_LEVEL;
          end
        end
        DATA: begin
          if (bit_end_s && (bit_q == LAST_BIT)) begin
            state_d = STOP;
            cnt_d   = presc_q;
            tx_d    = UART_IDLE_LEVEL;
          end else if (bit_end_s) begin
            cnt_d   = presc_q;
            bit_d   = bit_q + BIT_W'(1);
            shift_d = {1'b0, shift_q[UART_DATA_BITS-1:1]};
            tx_d    = shift_q[1];
          end else begin
            cnt_d = cnt_q - PRESC_W'(1);
            tx_d  = shift_q[0];
          end
        end
        STOP: begin
          if (bit_end_s) begin
            state_d = IDLE;
            tx_d    = UART_IDLE_LEVEL;
          end else begin
            cnt_d = cnt_q - PRESC_W'(1);
            tx_d  = UART_IDLE_LEVEL;
          end
        end
        default: begin
          state_d = IDLE;
          tx_d    = UART_IDLE_LEVEL;
        end
      endcase
    end
    // done is registered, so it is raised for the cycle that will be the last stop cycle.
    done_d = (state_d == STOP) && (cnt_d == '0);
  end

  // Sticky overflow: a dropped write wins over a simultaneous clear.
  always_comb begin
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      presc_q <= '0;
      shift_q <= '0;
      bit_q   <= '0;
      tx_q    <= UART_IDLE_LEVEL;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      presc_q <= presc_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign tx       = tx_q;
  assign done     = done_q;
  assign busy     = (state_q != IDLE);
  assign overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo: frame shape, back-to-back frames,
// FIFO full/overflow, write-during-pop, enable drop and mid-frame reset.
module tb_uart_tx_fifo;

  logic        HCLK;
  logic        HRESETn;
  logic        en;
  logic [15:0] prescale;
  logic [7:0]  wdata;
  logic        wr;
  logic        full;
  logic        empty;
  logic [4:0]  level;
  logic        overflow;
  logic        ovf_clr;
  logic        busy;
  logic        done;
  logic        tx;

  int n_cmp = 0;
  int n_mis = 0;

  logic [9:0] cap_bits  [0:19];
  logic [4:0] cap_level [0:19];
  int         cap_done_cnt;
  int         cap_done_idx;
  int         cap_busy_cnt;

  uart_tx_fifo #(
    .FIFO_DEPTH (16),
    .PRESC_W    (16)
  ) dut (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .en       (en),
    .prescale (prescale),
    .wdata    (wdata),
    .wr       (wr),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow),
    .ovf_clr  (ovf_clr),
    .busy     (busy),
    .done     (done),
    .tx       (tx)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  // Caller has just observed the first start-bit cycle (sample 0).
  task automatic capture(input int p, input int nfr, input int drop_at);
    int per;
    int f;
    int r;
    int b;
    per = 10 * (p + 1);
    cap_done_cnt = 0;
    cap_done_idx = -1;
    cap_busy_cnt = 0;
    for (int j = 0; j < nfr * per; j++) begin
      if (j > 0) tick();
      if (j == drop_at) en = 1'b0;
      f = j / per;
      r = j % per;
      b = r / (p + 1);
      if (r == 0) cap_level[f] = level;
      if ((r % (p + 1)) == (p / 2)) cap_bits[f][b] = tx;
      if (done) begin
        cap_done_cnt++;
        cap_done_idx = j;
      end
      if (busy) cap_busy_cnt++;
    end
  endtask

  initial begin
    int tx_low;
    int busy_cnt;
    logic [7:0] exp_b;

    HRESETn  = 1'b0;
    en       = 1'b0;
    prescale = 16'd0;
    wdata    = 8'h00;
    wr       = 1'b0;
    ovf_clr  = 1'b0;
    #12;
    check_eq("rst_tx", tx, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_full", full, 0);
    check_eq("rst_empty", empty, 1);
    check_eq("rst_level", level, 0);
    check_eq("rst_ovf", overflow, 0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    tick();

    // Single 0x41 frame at 16 clocks per bit.
    prescale = 16'd15;
    en = 1'b1;
    wr = 1'b1;
    wdata = 8'h41;
    tick();
    wr = 1'b0;
    check_eq("a_level1", level, 1);
    check_eq("a_tx_before_fall", tx, 1);
    tick();
    check_eq("a_tx_fall", tx, 0);
    check_eq("a_busy", busy, 1);
    capture(15, 1, -1);
    check_eq("a_frame", cap_bits[0], 10'h282);
    check_eq("a_done_cnt", cap_done_cnt, 1);
    check_eq("a_done_idx", cap_done_idx, 159);
    check_eq("a_busy_cnt", cap_busy_cnt, 160);
    $display("terminal: %c", cap_bits[0][8:1]);
    tick();
    check_eq("a_idle_tx", tx, 1);
    check_eq("a_idle_busy", busy, 0);
    check_eq("a_idle_done", done, 0);

    // Back-to-back 0x55, 0xAA at 1 clock per bit.
    prescale = 16'd0;
    en = 1'b0;
    wr = 1'b1;
    wdata = 8'h55;
    tick();
    check_eq("b_level1", level, 1);
    wdata = 8'hAA;
    tick();
    check_eq("b_level2", level, 2);
    wr = 1'b0;
    en = 1'b1;
    tick();
    check_eq("b_tx_fall", tx, 0);
    capture(0, 2, -1);
    check_eq("b_frame0", cap_bits[0], 10'h2AA);
    check_eq("b_frame1", cap_bits[1], 10'h354);
    check_eq("b_level_f0", cap_level[0], 1);
    check_eq("b_level_f1", cap_level[1], 0);
    check_eq("b_busy_cnt", cap_busy_cnt, 20);
    check_eq("b_done_cnt", cap_done_cnt, 2);
    check_eq("b_done_idx", cap_done_idx, 19);
    tick();
    check_eq("b_idle_tx", tx, 1);
    check_eq("b_idle_busy", busy, 0);

    // Fill with en low, then overflow and its clear behaviour.
    en = 1'b0;
    tx_low = 0;
    for (int i = 0; i < 16; i++) begin
      wr = 1'b1;
      wdata = 8'(i);
      tick();
      if (tx !== 1'b1) tx_low++;
    end
    check_eq("c_full", full, 1);
    check_eq("c_level16", level, 16);
    check_eq("c_ovf_before", overflow, 0);
    wdata = 8'h99;
    tick();
    check_eq("c_ovf_set", overflow, 1);
    check_eq("c_level_drop", level, 16);
    wr = 1'b0;
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check_eq("c_ovf_clr", overflow, 0);
    wr = 1'b1;
    wdata = 8'h98;
    ovf_clr = 1'b1;
    tick();
    wr = 1'b0;
    ovf_clr = 1'b0;
    check_eq("c_ovf_set_wins", overflow, 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check_eq("c_ovf_clr2", overflow, 0);
    if (tx !== 1'b1) tx_low++;
    check_eq("c_tx_high", tx_low, 0);
    check_eq("c_busy", busy, 0);

    // Write in the pop cycle while full: accepted, order preserved.
    en = 1'b1;
    wr = 1'b1;
    wdata = 8'h10;
    tick();
    wr = 1'b0;
    check_eq("d_level", level, 16);
    check_eq("d_ovf", overflow, 0);
    check_eq("d_tx_fall", tx, 0);
    capture(0, 17, -1);
    for (int f = 0; f < 17; f++) begin
      exp_b = 8'(f);
      check_eq($sformatf("d_frame%0d", f), cap_bits[f], 10'h200 | {1'b0, exp_b, 1'b0});
    end
    check_eq("d_done_cnt", cap_done_cnt, 17);
    tick();
    check_eq("d_empty", empty, 1);
    check_eq("d_idle_tx", tx, 1);

    // Drop en during data bit 3 of 0x3C with two bytes queued behind it.
    prescale = 16'd3;
    en = 1'b0;
    wr = 1'b1;
    wdata = 8'h3C;
    tick();
    wdata = 8'h11;
    tick();
    wdata = 8'h22;
    tick();
    wr = 1'b0;
    en = 1'b1;
    tick();
    check_eq("e_tx_fall", tx, 0);
    check_eq("e_level_start", level, 2);
    capture(3, 1, 17);
    check_eq("e_frame", cap_bits[0], 10'h278);
    check_eq("e_done_cnt", cap_done_cnt, 1);
    check_eq("e_done_idx", cap_done_idx, 39);
    tx_low = 0;
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tx !== 1'b1) tx_low++;
      if (busy !== 1'b0) busy_cnt++;
    end
    check_eq("e_no_start", tx_low, 0);
    check_eq("e_no_busy", busy_cnt, 0);
    check_eq("e_level_hold", level, 2);
    en = 1'b1;
    tick();
    check_eq("e_resume_fall", tx, 0);
    check_eq("e_resume_level", level, 1);
    capture(3, 2, -1);
    check_eq("e_frame_11", cap_bits[0], 10'h222);
    check_eq("e_frame_22", cap_bits[1], 10'h244);

    // Asynchronous reset in the middle of a data bit.
    tick();
    prescale = 16'd7;
    en = 1'b0;
    wr = 1'b1;
    wdata = 8'h5A;
    tick();
    wdata = 8'h33;
    tick();
    wr = 1'b0;
    en = 1'b1;
    tick();
    check_eq("f_tx_fall", tx, 0);
    for (int i = 0; i < 20; i++) tick();
    check_eq("f_busy_pre", busy, 1);
    HRESETn = 1'b0;
    #1;
    check_eq("f_rst_tx", tx, 1);
    check_eq("f_rst_busy", busy, 0);
    check_eq("f_rst_empty", empty, 1);
    check_eq("f_rst_level", level, 0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    tick();
    check_eq("f_post_tx", tx, 1);
    wr = 1'b1;
    wdata = 8'h0D;
    tick();
    wr = 1'b0;
    check_eq("f_level1", level, 1);
    tick();
    check_eq("f_fall", tx, 0);
    capture(7, 1, -1);
    check_eq("f_frame", cap_bits[0], 10'h21A);
    check_eq("f_done_cnt", cap_done_cnt, 1);
    tx_low = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (tx !== 1'b1) tx_low++;
    end
    check_eq("f_no_stale", tx_low, 0);
    check_eq("f_empty_end", empty, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
